// File: rtl/sfifo_pop_unpacker.sv
// ---------------------------------------------------------------------------
// sfifo_pop_unpacker
//
// Read-side drain engine for a single-clock synchronous FIFO. It issues POP
// against the FIFO Empty flag, captures DOUT one cycle later into a two-word
// prefetch buffer, and splits each buffered word into RATIO narrower subwords
// presented on a valid/ready stream.
//
// Parameters
//   FIFO_DATA_WIDTH : width of the FIFO read data
//   OUT_DATA_WIDTH  : subword width; RATIO = FIFO_DATA_WIDTH/OUT_DATA_WIDTH
//                     must be 1, 2 or 4
//   LSB_FIRST       : 1 emits the least significant slice first, 0 the most
//
// Ports
//   clock0         in   sole clock, rising edge
//   Sync_Reset_n   in   synchronous active-low reset
//   Flush          in   synchronous discard of buffered and in-flight data
//   Empty          in   FIFO empty flag
//   DOUT           in   FIFO read data, valid the cycle after POP
//   Underrun_Error in   FIFO underrun flag
//   POP            out  FIFO read strobe (combinational)
//   M_VALID        out  subword available
//   M_READY        in   consumer accepts the current subword
//   M_DATA         out  current subword (0 while M_VALID is low)
//   M_LAST         out  current subword is the final slice of its word
//   Protocol_Error out  sticky underrun indication, cleared by reset only
//   Word_Count     out  words popped since reset or flush, wraps
// ---------------------------------------------------------------------------
module sfifo_pop_unpacker #(
   parameter int FIFO_DATA_WIDTH = 36,
   parameter int OUT_DATA_WIDTH  = 9,
   parameter bit LSB_FIRST       = 1'b1
) (
   input  logic                       clock0,
   input  logic                       Sync_Reset_n,
   input  logic                       Flush,
   input  logic                       Empty,
   input  logic [FIFO_DATA_WIDTH-1:0] DOUT,
   input  logic                       Underrun_Error,
   output logic                       POP,
   output logic                       M_VALID,
   input  logic                       M_READY,
   output logic [OUT_DATA_WIDTH-1:0]  M_DATA,
   output logic                       M_LAST,
   output logic                       Protocol_Error,
   output logic [15:0]                Word_Count
);

   localparam int RATIO = FIFO_DATA_WIDTH / OUT_DATA_WIDTH;
   localparam int SUB_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(RATIO - 1);

   generate
      if (!((RATIO == 1) || (RATIO == 2) || (RATIO == 4))) begin : g_bad_ratio
         $error("sfifo_pop_unpacker: FIFO_DATA_WIDTH/OUT_DATA_WIDTH must be 1, 2 or 4");
      end
   endgenerate

   // Two-entry circular buffer; head_reg points at the word being unpacked.
   logic [FIFO_DATA_WIDTH-1:0] slot_reg [0:1];
   logic                       head_reg;
   logic                       head_next;
   logic [1:0]                 held_reg;
   logic [1:0]                 held_next;
   logic                       pending_reg;
   logic [SUB_W-1:0]           sub_reg;
   logic [SUB_W-1:0]           sub_next;
   logic                       perr_reg;
   logic [15:0]                count_reg;

   logic                       handshake;
   logic                       sub_is_last;
   logic                       release_word;
   logic                       wr_slot;
   logic [SUB_W-1:0]           sel_idx;
   logic [FIFO_DATA_WIDTH-1:0] head_word;
   logic [OUT_DATA_WIDTH-1:0]  slice_mux;
   logic [OUT_DATA_WIDTH-1:0]  slices [RATIO];

   assign M_VALID      = (held_reg != 2'd0);
   assign handshake    = M_VALID & M_READY;
   assign sub_is_last  = (sub_reg == SUB_LAST);
   assign release_word = handshake & sub_is_last;

   // Occupancy after this edge: arriving word in, retiring word out. A pop
   // is only allowed when that leaves room for the word it will return, so
   // held + pending never exceeds two.
   assign held_next = held_reg + 2'(pending_reg) - 2'(release_word);
   assign POP       = Sync_Reset_n & ~Flush & ~Empty & (held_next < 2'd2);

   // When a word is arriving, held is at most one, so the first free slot is
   // head + held (mod 2). If the head retires in the same cycle the written
   // slot becomes the new head, which is exactly what is wanted.
   assign wr_slot   = head_reg ^ held_reg[0];
   assign head_next = head_reg ^ release_word;

   always_comb begin
      sub_next = sub_reg;
      if (handshake) begin
         if (sub_is_last) begin
            sub_next = '0;
         end else begin
            sub_next = sub_reg + 1'b1;
         end
      end
   end

   // Slice selection: MSB-first simply walks the slice index downwards.
   assign head_word = slot_reg[head_reg];
   assign sel_idx   = LSB_FIRST ? sub_reg : (SUB_LAST - sub_reg);

   genvar gi;
   generate
      for (gi = 0; gi < RATIO; gi++) begin : g_slice
         assign slices[gi] = head_word[gi*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
      end
   endgenerate

   always_comb begin
      slice_mux = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (sel_idx == SUB_W'(i)) begin
            slice_mux = slices[i];
         end
      end
   end

   assign M_DATA         = M_VALID ? slice_mux : '0;
   assign M_LAST         = M_VALID & sub_is_last;
   assign Protocol_Error = perr_reg;
   assign Word_Count     = count_reg;

   // Control state.
   always_ff @(posedge clock0) begin
      if (!Sync_Reset_n) begin
         held_reg    <= 2'd0;
         pending_reg <= 1'b0;
         sub_reg     <= '0;
         head_reg    <= 1'b0;
         count_reg   <= 16'd0;
         perr_reg    <= 1'b0;
      end else begin
         if (Underrun_Error) begin
            perr_reg <= 1'b1;
         end
         if (Flush) begin
            // Clearing pending drops the word returned by last cycle's pop.
            held_reg    <= 2'd0;
            pending_reg <= 1'b0;
            sub_reg     <= '0;
            head_reg    <= 1'b0;
            count_reg   <= 16'd0;
         end else begin
            held_reg    <= held_next;
            pending_reg <= POP;
            sub_reg     <= sub_next;
            head_reg    <= head_next;
            if (POP) begin
               count_reg <= count_reg + 16'd1;
            end
         end
      end
   end

   // Data storage has no reset; a slot written during flush or reset is
   // never presented because held is cleared at the same edge.
   always_ff @(posedge clock0) begin
      if (pending_reg) begin
         slot_reg[wr_slot] <= DOUT;
      end
   end

endmodule

// File: tb/tb_sfifo_pop_unpacker.sv
// ---------------------------------------------------------------------------
// tb_sfifo_pop_unpacker
//
// Four instances cover ratio 4, ratio 1, ratio 2 LSB-first and ratio 2
// MSB-first. One instance is selected at a time; the others see an empty
// FIFO and no ready. A small FIFO model answers POP with DOUT one cycle
// later. Expected subwords are queued as stimulus is loaded and a monitor
// pops and compares them on every output handshake.
// ---------------------------------------------------------------------------
module tb_sfifo_pop_unpacker;

   typedef struct {
      logic [35:0] data;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        underrun;
   logic        m_ready;
   logic [35:0] dout;
   int          sel;

   logic [35:0] fifo_mem [0:63];
   int          rd_ptr;
   int          wr_ptr;
   logic        fifo_empty;

   exp_t        exp_q [$];
   int          vecs;
   int          errs;

   always #5 clk = ~clk;

   assign fifo_empty = (rd_ptr == wr_ptr);

   logic [3:0]  inst_empty;
   logic [3:0]  inst_ready;
   logic [3:0]  pop_w;
   logic [3:0]  valid_w;
   logic [3:0]  last_w;
   logic [3:0]  perr_w;
   logic [15:0] wc_w [4];
   logic [8:0]  data_r4;
   logic [35:0] data_r1;
   logic [17:0] data_r2;
   logic [17:0] data_r2m;

   for (genvar gi = 0; gi < 4; gi++) begin : g_gate
      assign inst_empty[gi] = (sel != gi) | fifo_empty;
      assign inst_ready[gi] = (sel == gi) & m_ready;
   end

   sfifo_pop_unpacker #(.FIFO_DATA_WIDTH(36), .OUT_DATA_WIDTH(9), .LSB_FIRST(1'b1)) u_r4 (
      .clock0(clk), .Sync_Reset_n(rst_n), .Flush(flush), .Empty(inst_empty[0]),
      .DOUT(dout), .Underrun_Error(underrun), .POP(pop_w[0]), .M_VALID(valid_w[0]),
      .M_READY(inst_ready[0]), .M_DATA(data_r4), .M_LAST(last_w[0]),
      .Protocol_Error(perr_w[0]), .Word_Count(wc_w[0]));

   sfifo_pop_unpacker #(.FIFO_DATA_WIDTH(36), .OUT_DATA_WIDTH(36), .LSB_FIRST(1'b1)) u_r1 (
      .clock0(clk), .Sync_Reset_n(rst_n), .Flush(flush), .Empty(inst_empty[1]),
      .DOUT(dout), .Underrun_Error(underrun), .POP(pop_w[1]), .M_VALID(valid_w[1]),
      .M_READY(inst_ready[1]), .M_DATA(data_r1), .M_LAST(last_w[1]),
      .Protocol_Error(perr_w[1]), .Word_Count(wc_w[1]));

   sfifo_pop_unpacker #(.FIFO_DATA_WIDTH(36), .OUT_DATA_WIDTH(18), .LSB_FIRST(1'b1)) u_r2 (
      .clock0(clk), .Sync_Reset_n(rst_n), .Flush(flush), .Empty(inst_empty[2]),
      .DOUT(dout), .Underrun_Error(underrun), .POP(pop_w[2]), .M_VALID(valid_w[2]),
      .M_READY(inst_ready[2]), .M_DATA(data_r2), .M_LAST(last_w[2]),
      .Protocol_Error(perr_w[2]), .Word_Count(wc_w[2]));

   sfifo_pop_unpacker #(.FIFO_DATA_WIDTH(36), .OUT_DATA_WIDTH(18), .LSB_FIRST(1'b0)) u_r2m (
      .clock0(clk), .Sync_Reset_n(rst_n), .Flush(flush), .Empty(inst_empty[3]),
      .DOUT(dout), .Underrun_Error(underrun), .POP(pop_w[3]), .M_VALID(valid_w[3]),
      .M_READY(inst_ready[3]), .M_DATA(data_r2m), .M_LAST(last_w[3]),
      .Protocol_Error(perr_w[3]), .Word_Count(wc_w[3]));

   // Outputs of the selected instance.
   logic        mon_pop;
   logic        mon_valid;
   logic        mon_last;
   logic        mon_perr;
   logic [15:0] mon_wc;
   logic [35:0] mon_data;

   assign mon_pop   = pop_w[sel[1:0]];
   assign mon_valid = valid_w[sel[1:0]];
   assign mon_last  = last_w[sel[1:0]];
   assign mon_perr  = perr_w[sel[1:0]];
   assign mon_wc    = wc_w[sel[1:0]];
   assign mon_data  = (sel == 0) ? {27'd0, data_r4} :
                      (sel == 1) ? data_r1 :
                      (sel == 2) ? {18'd0, data_r2} : {18'd0, data_r2m};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vecs++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [35:0] w);
      fifo_mem[wr_ptr] = w;
      wr_ptr++;
   endtask

   // Expected subwords of one FIFO word, in emission order.
   task automatic push_word(input logic [35:0] w, input int ratio, input bit lsb);
      int          ow;
      int          idx;
      logic [63:0] mask;
      exp_t        e;
      ow   = 36 / ratio;
      mask = (64'h1 << ow) - 64'h1;
      for (int i = 0; i < ratio; i++) begin
         idx    = lsb ? i : (ratio - 1 - i);
         e.data = 36'(({28'd0, w} >> (idx * ow)) & mask);
         e.last = (i == ratio - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic push_exp(input logic [35:0] d, input logic l);
      exp_t e;
      e.data = d;
      e.last = l;
      exp_q.push_back(e);
   endtask

   // Select an instance, apply one reset edge and check the reset state.
   task automatic start_test(input int k, input string tag);
      sel      = k;
      rst_n    = 1'b0;
      flush    = 1'b0;
      m_ready  = 1'b0;
      underrun = 1'b0;
      exp_q.delete();
      tick();
      check({tag, "_rst_pop"},   64'(mon_pop),   64'd0);
      check({tag, "_rst_valid"}, 64'(mon_valid), 64'd0);
      check({tag, "_rst_data"},  64'(mon_data),  64'd0);
      check({tag, "_rst_last"},  64'(mon_last),  64'd0);
      check({tag, "_rst_perr"},  64'(mon_perr),  64'd0);
      check({tag, "_rst_wc"},    64'(mon_wc),    64'd0);
   endtask

   initial begin
      vecs     = 0;
      errs     = 0;
      rd_ptr   = 0;
      wr_ptr   = 0;
      sel      = 0;
      rst_n    = 1'b0;
      flush    = 1'b0;
      underrun = 1'b0;
      m_ready  = 1'b0;
      dout     = '0;

      fork
         // FIFO model: read data appears the cycle after POP.
         forever begin
            @(posedge clk);
            if (mon_pop) begin
               dout   <= fifo_mem[rd_ptr];
               rd_ptr <= rd_ptr + 1;
            end
         end
         // Scoreboard monitor: compare on every accepted subword.
         forever begin
            @(negedge clk);
            if (mon_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  vecs++;
                  errs++;
                  $display("FAIL unexpected_beat: got data %0h last %0b, required none", mon_data, mon_last);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("beat_data", 64'(mon_data), 64'(e.data));
                  check("beat_last", 64'(mon_last), 64'(e.last));
               end
            end
         end
      join_none

      // Ratio 4, one word, LSB first.
      start_test(0, "r4");
      load(36'h1_2345_6789);
      push_exp(36'h189, 1'b0);
      push_exp(36'h0B3, 1'b0);
      push_exp(36'h0D1, 1'b0);
      push_exp(36'h024, 1'b1);
      m_ready = 1'b1;
      rst_n   = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1;
         check($sformatf("r4_pop_c%0d", c),   64'(mon_pop),   64'(c == 0));
         check($sformatf("r4_valid_c%0d", c), 64'(mon_valid), 64'(c >= 2 && c <= 5));
         tick();
      end
      check("r4_wc", 64'(mon_wc), 64'd1);
      check("r4_drained", 64'(exp_q.size()), 64'd0);

      // Ratio 1 streaming of 8 words.
      start_test(1, "r1");
      for (int i = 0; i < 8; i++) begin
         load(36'h3_C0DE_0000 + 36'(i * 17));
         push_word(36'h3_C0DE_0000 + 36'(i * 17), 1, 1'b1);
      end
      m_ready = 1'b1;
      rst_n   = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         check($sformatf("r1_pop_c%0d", c),   64'(mon_pop),   64'(c < 8));
         check($sformatf("r1_valid_c%0d", c), 64'(mon_valid), 64'(c >= 2 && c < 10));
         tick();
      end
      check("r1_wc", 64'(mon_wc), 64'd8);
      check("r1_drained", 64'(exp_q.size()), 64'd0);

      // Ratio 2 backpressure with 5 words queued.
      start_test(2, "bp");
      load(36'h1_0000_3ABC);
      push_word(36'h1_0000_3ABC, 2, 1'b1);
      for (int i = 1; i < 5; i++) begin
         load(36'h2_1111_0000 + 36'(i));
         push_word(36'h2_1111_0000 + 36'(i), 2, 1'b1);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         check($sformatf("bp_pop_c%0d", c),   64'(mon_pop),   64'(c < 2));
         check($sformatf("bp_valid_c%0d", c), 64'(mon_valid), 64'(c >= 2));
         if (c >= 2) begin
            check($sformatf("bp_data_c%0d", c), 64'(mon_data), 64'h3ABC);
         end
         tick();
      end
      m_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         check($sformatf("bp_drain_valid_c%0d", c), 64'(mon_valid), 64'(c < 10));
         tick();
      end
      check("bp_wc", 64'(mon_wc), 64'd5);
      check("bp_drained", 64'(exp_q.size()), 64'd0);

      // Flush with one word held and one in flight.
      start_test(1, "fl");
      load(36'hA_0000_0000);
      load(36'hA_0000_0001);
      load(36'hA_0000_0002);
      load(36'hA_0000_0003);
      push_word(36'hA_0000_0002, 1, 1'b1);
      push_word(36'hA_0000_0003, 1, 1'b1);
      rst_n = 1'b1;
      flush = 1'b1;
      #1;
      check("fl_pop_during_flush", 64'(mon_pop), 64'd0);
      tick();
      flush = 1'b0;
      #1;
      check("fl_idle_wc", 64'(mon_wc), 64'd0);
      check("fl_pop_c0", 64'(mon_pop), 64'd1);
      tick();
      check("fl_pop_c1", 64'(mon_pop), 64'd1);
      tick();
      flush = 1'b1;
      #1;
      check("fl_valid_c2", 64'(mon_valid), 64'd1);
      check("fl_pop_c2",   64'(mon_pop),   64'd0);
      tick();
      flush = 1'b0;
      #1;
      check("fl_valid_after", 64'(mon_valid), 64'd0);
      check("fl_wc_after",    64'(mon_wc),    64'd0);
      check("fl_pop_after",   64'(mon_pop),   64'd1);
      tick();
      tick();
      m_ready = 1'b1;
      repeat (6) tick();
      check("fl_wc_end", 64'(mon_wc), 64'd2);
      check("fl_drained", 64'(exp_q.size()), 64'd0);

      // Sticky error, then reset mid-stream.
      start_test(2, "er");
      rst_n    = 1'b1;
      underrun = 1'b1;
      tick();
      underrun = 1'b0;
      #1;
      check("er_perr_set", 64'(mon_perr), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check("er_perr_after_flush", 64'(mon_perr), 64'd1);
      load(36'h5_5555_AAAA);
      push_word(36'h5_5555_AAAA, 2, 1'b1);
      load(36'h6_0000_0001);
      load(36'h6_0000_0002);
      load(36'h6_0000_0003);
      m_ready = 1'b1;
      repeat (4) tick();
      rst_n   = 1'b0;
      m_ready = 1'b0;
      wr_ptr  = rd_ptr;
      #1;
      check("er_pop_in_reset", 64'(mon_pop), 64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("er_post_pop",   64'(mon_pop),   64'd0);
      check("er_post_valid", 64'(mon_valid), 64'd0);
      check("er_post_data",  64'(mon_data),  64'd0);
      check("er_post_last",  64'(mon_last),  64'd0);
      check("er_post_perr",  64'(mon_perr),  64'd0);
      check("er_post_wc",    64'(mon_wc),    64'd0);
      check("er_drained", 64'(exp_q.size()), 64'd0);

      // Ratio 2, MSB first.
      start_test(3, "msb");
      load(36'hA_BCDE_F012);
      push_exp(36'h2AF37, 1'b0);
      push_exp(36'h2F012, 1'b1);
      m_ready = 1'b1;
      rst_n   = 1'b1;
      repeat (6) tick();
      check("msb_wc", 64'(mon_wc), 64'd1);
      check("msb_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
